pipe_square_mul: RTL

//  Parametrised, pipelined squarer/multiplier; next generation of the registered n*n core.
//  - Adds selectable operand width, pipeline depth, signedness, square/multiply mode and tag pass-through.
//  - Adds valid/ready flow control on both sides.
//  - Sits between a producer stream and a consumer stream inside top-level wrappers.

---
 rtl/pipe_square_mul_if.sv | 32 +++
 rtl/pipe_square_mul.sv | 98 +++++++++
 2 files changed

// File: rtl/pipe_square_mul_if.sv
// Producer/consumer bundle for pipe_square_mul: input op stream, result stream and stats taps.
// The design side uses the slave modport and the environment side uses the master modport.
interface pipe_square_mul_if #(
    parameter int W     = 4,
    parameter int TAG_W = 2,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic [W-1:0]       in_a;
    logic [W-1:0]       in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*W-1:0]     out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               stat_clr;
    logic [CNT_W-1:0]   stat_in;
    logic [CNT_W-1:0]   stat_out;
    logic [CNT_W-1:0]   stat_stall;

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_tag, out_ready, stat_clr,
        output in_ready, out_valid, out_data, out_tag, stat_in, stat_out, stat_stall
    );

    modport master (
        output in_valid, in_mode, in_a, in_b, in_tag, out_ready, stat_clr,
        input  in_ready, out_valid, out_data, out_tag, stat_in, stat_out, stat_stall
    );
endinterface

// File: rtl/pipe_square_mul.sv
// Pipelined square/multiply, LAT cycles accept-to-valid; a stalled output freezes every stage and drops in_ready.
// Optional statistics counters are built only when PSM_STATS_EN is defined.
module pipe_square_mul #(
    parameter int W      = 4,
    parameter int LAT    = 2,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_square_mul_if.slave  bus
);
    localparam int PW = 2 * W;

    logic [LAT-1:0]    vld_q;
    logic [PW-1:0]     prod_q [LAT];
    logic [TAG_W-1:0]  tag_q  [LAT];

    logic [W-1:0]      op_b;
    logic [PW-1:0]     ext_a;
    logic [PW-1:0]     ext_b;
    logic [PW-1:0]     prod_d;
    logic              stall;
    logic              in_rdy;
    logic              acc;

    // Truncating the 2W-bit product of extended operands gives the exact two's-complement result.
    always_comb begin
        op_b   = bus.in_mode ? bus.in_b : bus.in_a;
        ext_a  = (SIGNED != 0) ? {{W{bus.in_a[W-1]}}, bus.in_a} : {{W{1'b0}}, bus.in_a};
        ext_b  = (SIGNED != 0) ? {{W{op_b[W-1]}}, op_b} : {{W{1'b0}}, op_b};
        prod_d = ext_a * ext_b;
        stall  = vld_q[LAT-1] & ~bus.out_ready;
        in_rdy = ~stall & ~rst;
        acc    = bus.in_valid & in_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (!stall) begin
            vld_q[0]  <= acc;
            prod_q[0] <= acc ? prod_d : '0;
            tag_q[0]  <= acc ? bus.in_tag : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_q[LAT-1];
    assign bus.out_data  = prod_q[LAT-1];
    assign bus.out_tag   = tag_q[LAT-1];

`ifdef PSM_STATS_EN
    logic [CNT_W-1:0] stat_in_q;
    logic [CNT_W-1:0] stat_out_q;
    logic [CNT_W-1:0] stat_stall_q;
    logic             out_xfer;

    assign out_xfer = vld_q[LAT-1] & bus.out_ready;

    // Saturating counters; clear wins over any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.stat_clr) begin
            stat_in_q    <= '0;
            stat_out_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (acc && (stat_in_q != '1))
                stat_in_q <= stat_in_q + 1'b1;
            if (out_xfer && (stat_out_q != '1))
                stat_out_q <= stat_out_q + 1'b1;
            if (stall && (stat_stall_q != '1))
                stat_stall_q <= stat_stall_q + 1'b1;
        end
    end

    assign bus.stat_in    = stat_in_q;
    assign bus.stat_out   = stat_out_q;
    assign bus.stat_stall = stat_stall_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = bus.stat_clr;
    assign bus.stat_in     = '0;
    assign bus.stat_out    = '0;
    assign bus.stat_stall  = '0;
`endif
endmodule
